uart_prog_loader: RTL
=====================

// Module: uart_prog_loader
// PURPOSE
//  UART boot loader that fills main memory over the iomem-side RAM write port while holding the core in reset.
//  - Sits between the board RX pin and the main RAM write port.
//  - Listens for a 4-byte magic sequence, then a 32-bit word count, then that many 32-bit words.
//  - Writes the words to consecutive word addresses from 0, then releases system reset.
//  - system_reset_o is ANDed with the board reset by the top level.
// PARAMETERS
//  CLK_FREQ_HZ     60_000_000  system clock frequency
//  BAUD            115200      UART bit rate; DIV = CLK_FREQ_HZ/BAUD (integer, truncated)
//  WORD_ADDR_W     21          RAM word-address width
//  RAM_WORDS       1430000     RAM depth in 32-bit words
//  MAGIC           32'h4E4B4554 magic word, sent LSB first: bytes 0x54 0x45 0x4B 0x4E ("TEKN")
//  TIMEOUT_CYCLES  6_000_000   maximum idle gap between bytes while loading (100 ms)
// PORTS
//  clk_i           in   1            system clock
//  rst_i           in   1            synchronous reset, active-high
//  rx_i            in   1            UART RX pin, asynchronous, idle high
//  wr_en_o         out  1            one-cycle RAM write pulse
//  wr_addr_o       out  WORD_ADDR_W  RAM word address
//  wr_data_o       out  32           RAM write data, little-endian byte assembly
//  wr_strb_o       out  4            byte strobes: 4'hF when wr_en_o=1, else 4'h0
//  system_reset_o  out  1            active-low core reset; 0 while loading
//  prog_mode_led_o out  1            1 while loading
//  err_o           out  1            one-cycle pulse on timeout or oversize count
// BEHAVIOUR
//  Reset values:
//  - wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_strb_o=0.
//  - system_reset_o=1, prog_mode_led_o=0, err_o=0.
//  - FSM in S_SYNC; magic shift register = 0.
//  UART receive:
//  - rx_i passes through a 2-FF synchronizer.
//  - Start bit is a falling edge; it is re-checked low at DIV/2. If high, it is treated as a glitch: return to idle, no byte.
//  - 8 data bits are sampled LSB first, DIV cycles apart, at bit centre.
//  - Stop bit sampled 0 means framing error: the byte is dropped, no byte_valid.
//  - byte_valid is a 1-cycle pulse, registered.
//  FSM:
//  - S_SYNC: each byte is shifted into a 32-bit register as {byte, reg[31:8]}. When the register equals MAGIC:
//    - go to S_LEN; system_reset_o<=0 and prog_mode_led_o<=1 on the next edge;
//    - byte counter and timeout counter <= 0.
//  - S_LEN: collect 4 bytes, little-endian, into the count.
//    - count==0: go to S_DONE.
//    - count>RAM_WORDS: err_o pulse, go to S_SYNC, release reset.
//    - otherwise: go to S_DATA with wr_addr_o=0.
//  - S_DATA: collect 4 bytes per word. On the cycle after the 4th byte_valid:
//    - wr_en_o=1, wr_strb_o=F, wr_data_o=assembled word, for exactly one cycle;
//    - wr_addr_o increments after the pulse.
//    - The write pulse that brings the written count to count goes to S_DONE.
//  - S_DONE: one cycle.
//    - system_reset_o<=1, prog_mode_led_o<=0;
//    - clear the magic register; go to S_SYNC.
//  Timeout and boundaries:
//  - In S_LEN/S_DATA the timeout counter increments every cycle and clears on byte_valid.
//  - Counter reaching TIMEOUT_CYCLES-1 gives err_o pulse, go to S_SYNC, system_reset_o<=1. Partial words are discarded.
//  - byte_valid and timeout in the same cycle: the byte wins, no timeout.
//  - Bytes in S_LEN/S_DATA are payload only; the magic is not rescanned.
//  - The RAM write port is never stalled: a word takes ≥40 bit times, far above the 1-cycle write.
//  - rst_i mid-load: returns to reset values immediately, including system_reset_o=1. There are no partial writes after the reset edge.
//  - wr_addr_o width arithmetic wraps modulo 2^WORD_ADDR_W; this is unreachable because count is bounded by RAM_WORDS.
// STRUCTURE
//  - Shared package: FSM state encoding (S_SYNC, S_LEN, S_DATA, S_DONE); default MAGIC constant; RAM_BASE_ADDR/RAM_MASK_ADDR constants.
//  - One sub-module: uart_rx_byte (synchronizer, baud counter, bit FSM; outputs byte_o[7:0], byte_valid_o).
//  - Top: magic matcher, length/word assembler, write FSM, timeout counter.
// TESTING
//  Benches use BAUD = CLK_FREQ_HZ/16 for fast runs.
//  1 Normal load
//    - Stimulus: 54 45 4B 4E, 02 00 00 00, 78 56 34 12, EF BE AD DE.
//    - Response: writes (addr 0, 0x12345678), (addr 1, 0xDEADBEEF), strb F.
//    - Response: system_reset_o low from the cycle after 0x4E until 1 cycle after the 2nd write.
//  2 Zero count
//    - Stimulus: magic + 00 00 00 00.
//    - Response: no wr_en_o; system_reset_o returns to 1 after S_DONE; err_o stays 0.
//  3 Oversize count
//    - Stimulus: magic + count RAM_WORDS+1.
//    - Response: err_o 1-cycle pulse, no writes, system_reset_o=1, FSM in S_SYNC.
//  4 Timeout
//    - Stimulus: magic, count 1, 2 data bytes, then idle TIMEOUT_CYCLES.
//    - Response: err_o pulse, no write, reset released.
//    - Stimulus: then a fresh full sequence.
//    - Response: loads correctly.
//  5 Framing and glitch
//    - Stimulus: a byte with stop bit 0 inside the magic; a 0.25-bit low glitch on rx_i.
//    - Response: neither produces byte_valid; the magic is not matched.
//  6 Reset mid-load
//    - Stimulus: rst_i high for 1 cycle after the 5th data byte.
//    - Response: all outputs at reset values next cycle; later bytes are ignored until a new magic.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings,
// the default boot magic and the RAM word-address window.
package uart_prog_loader_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    S_SYNC,
    S_LEN,
    S_DATA,
    S_DONE
  } state_t;

  // UART receiver bit-level states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // "TEKN" sent LSB first: 0x54 0x45 0x4B 0x4E
  localparam logic [31:0] MAGIC_DEFAULT = 32'h4E4B_4554;

  // Program image starts at word 0; addresses wrap within the RAM window
  localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK_ADDR = 32'h001F_FFFF;

endpackage

// File: rtl/uart_prog_loader_if.sv
// RAM write port between the loader (master) and main memory (slave).
interface uart_prog_loader_if #(
  parameter int WORD_ADDR_W = 21
);
  logic                   wr_en;
  logic [WORD_ADDR_W-1:0] wr_addr;
  logic [31:0]            wr_data;
  logic [3:0]             wr_strb;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_strb
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input wr_strb
  );
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, start-bit glitch filter,
// centre sampling, stop-bit check. Emits a registered 1-cycle byte_valid_o.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  logic            rx_meta_reg;
  logic            rx_sync_reg;
  logic            rx_prev_reg;
  rx_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic [7:0]      byte_reg;
  logic            valid_reg;

  // Bring the asynchronous pin into the clock domain; keep last value for edge detect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_i;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // Bit-timing FSM: confirm start at half bit, then sample each bit at its centre
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      byte_reg    <= '0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            state_reg <= RX_START;
            cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            // Line back high at mid start bit: a glitch, not a frame
            state_reg   <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg   <= '0;
            state_reg <= RX_IDLE;
            // A low stop bit is a framing error: drop the byte silently
            if (rx_sync_reg) begin
              byte_reg  <= shift_reg;
              valid_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = byte_reg;
  assign byte_valid_o = valid_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: waits for the magic word, reads a word count and that
// many little-endian words, writes them to RAM from word 0 while holding
// the core in reset, then releases it.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          CLK_FREQ_HZ    = 60_000_000,
  parameter int          BAUD           = 115200,
  parameter int          WORD_ADDR_W    = 21,
  parameter int          RAM_WORDS      = 1430000,
  parameter logic [31:0] MAGIC          = MAGIC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 6_000_000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_i,
  uart_prog_loader_if.master        ram,
  output logic                      system_reset_o,
  output logic                      prog_mode_led_o,
  output logic                      err_o
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]        TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]            MAX_WORDS = 32'(RAM_WORDS);
  localparam logic [WORD_ADDR_W-1:0] ADDR_BASE = RAM_BASE_ADDR[WORD_ADDR_W-1:0];
  localparam logic [WORD_ADDR_W-1:0] ADDR_MASK = RAM_MASK_ADDR[WORD_ADDR_W-1:0];

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid)
  );

  state_t                 state_reg;
  logic [31:0]            magic_reg;
  logic [1:0]             byte_cnt_reg;
  logic [31:0]            asm_reg;
  logic [31:0]            count_reg;
  logic [TO_W-1:0]        timeout_reg;
  logic                   wr_en_reg;
  logic [WORD_ADDR_W-1:0] wr_addr_reg;
  logic [31:0]            wr_data_reg;
  logic                   system_reset_reg;
  logic                   led_reg;
  logic                   err_reg;

  logic [31:0] magic_shift;
  logic [31:0] word_shift;
  logic [31:0] written_next;

  // Incoming byte always enters at the top: little-endian assembly
  assign magic_shift  = {rx_byte, magic_reg[31:8]};
  assign word_shift   = {rx_byte, asm_reg[31:8]};
  assign written_next = 32'(wr_addr_reg) + 32'd1;

  // Loader FSM: magic match, count capture, word writes, timeout supervision
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= S_SYNC;
      magic_reg        <= '0;
      byte_cnt_reg     <= '0;
      asm_reg          <= '0;
      count_reg        <= '0;
      timeout_reg      <= '0;
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= ADDR_BASE;
      wr_data_reg      <= '0;
      system_reset_reg <= 1'b1;
      led_reg          <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      err_reg   <= 1'b0;

      // Address advances right after each write pulse
      if (wr_en_reg) begin
        wr_addr_reg <= (wr_addr_reg + 1'b1) & ADDR_MASK;
      end

      case (state_reg)
        S_SYNC: begin
          if (rx_valid) begin
            if (magic_shift == MAGIC) begin
              state_reg        <= S_LEN;
              magic_reg        <= '0;
              system_reset_reg <= 1'b0;
              led_reg          <= 1'b1;
              byte_cnt_reg     <= '0;
              timeout_reg      <= '0;
            end else begin
              magic_reg <= magic_shift;
            end
          end
        end

        S_LEN, S_DATA: begin
          if (rx_valid) begin
            // A byte in the same cycle as the timeout limit wins
            timeout_reg  <= '0;
            asm_reg      <= word_shift;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
            if (byte_cnt_reg == 2'd3) begin
              if (state_reg == S_LEN) begin
                count_reg <= word_shift;
                if (word_shift == 32'd0) begin
                  state_reg <= S_DONE;
                end else if (word_shift > MAX_WORDS) begin
                  err_reg          <= 1'b1;
                  state_reg        <= S_SYNC;
                  system_reset_reg <= 1'b1;
                  led_reg          <= 1'b0;
                end else begin
                  state_reg   <= S_DATA;
                  wr_addr_reg <= ADDR_BASE;
                end
              end else begin
                wr_en_reg   <= 1'b1;
                wr_data_reg <= word_shift;
              end
            end
          end else if (timeout_reg == TO_LAST) begin
            err_reg          <= 1'b1;
            state_reg        <= S_SYNC;
            system_reset_reg <= 1'b1;
            led_reg          <= 1'b0;
          end else begin
            timeout_reg <= timeout_reg + 1'b1;
          end

          // The write that completes the image ends the load
          if (state_reg == S_DATA && wr_en_reg && written_next == count_reg) begin
            state_reg <= S_DONE;
          end
        end

        S_DONE: begin
          system_reset_reg <= 1'b1;
          led_reg          <= 1'b0;
          magic_reg        <= '0;
          state_reg        <= S_SYNC;
        end

        default: state_reg <= S_SYNC;
      endcase
    end
  end

  assign ram.wr_en   = wr_en_reg;
  assign ram.wr_addr = wr_addr_reg;
  assign ram.wr_data = wr_data_reg;

  // Every lane is enabled on a write, none otherwise
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
      assign ram.wr_strb[gi] = wr_en_reg;
    end
  endgenerate

  assign system_reset_o  = system_reset_reg;
  assign prog_mode_led_o = led_reg;
  assign err_o           = err_reg;

endmodule
